// File: rtl/shift_seq_ctrl.sv
// Command sequencer for a single bidirectional shift register.
// Takes one command at a time over valid/ready. It sets the shift
// direction, then serializes a data word (followed by fill bits) onto
// the register for a programmed number of enabled clocks. At the end it
// captures the register's parallel output and pulses done.
module shift_seq_ctrl #(
    parameter int MSB = 4,
    parameter int CW  = 5
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_dir,
    input  logic [CW-1:0]  cmd_len,
    input  logic [MSB-1:0] cmd_data,
    input  logic           cmd_fill,
    input  logic           abort,
    output logic           sr_d,
    output logic           sr_en,
    output logic           sr_dir,
    input  logic [MSB-1:0] sr_out,
    output logic           busy,
    output logic           done,
    output logic           aborted,
    output logic [MSB-1:0] result
);

    localparam int unsigned MsbU = MSB;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StSettle,
        StDone
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  len_q;
    logic [MSB-1:0] data_q;
    logic           fill_q;
    logic [CW-1:0]  cnt_q;
    logic           abort_hit_q;
    logic [CW-1:0]  cnt_inc;

    // Bit driven for shift index k: data word first, in the order that lands
    // it unreversed in the register, then fill bits.
    function automatic logic pick_bit(input logic [CW-1:0]  k,
                                      input logic [MSB-1:0] data,
                                      input logic           dir,
                                      input logic           fill);
        logic [MSB-1:0] sh_r;
        logic [MSB-1:0] sh_l;
        int unsigned    ku;
        ku   = 32'(k);
        sh_r = data >> k;
        sh_l = data << k;
        if (ku >= MsbU) begin
            return fill;
        end
        return dir ? sh_r[0] : sh_l[MSB-1];
    endfunction

    // Index of the shift that follows the one in progress
    always_comb begin
        cnt_inc = cnt_q + CW'(1);
    end

    // Sequencer FSM; every output is registered here
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            cmd_ready   <= 1'b1;
            sr_d        <= 1'b0;
            sr_en       <= 1'b0;
            sr_dir      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            result      <= '0;
            len_q       <= '0;
            data_q      <= '0;
            fill_q      <= 1'b0;
            cnt_q       <= '0;
            abort_hit_q <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid && cmd_ready) begin
                        len_q       <= cmd_len;
                        data_q      <= cmd_data;
                        fill_q      <= cmd_fill;
                        // Direction goes out now so it is stable during SETUP
                        sr_dir      <= cmd_dir;
                        abort_hit_q <= 1'b0;
                        cmd_ready   <= 1'b0;
                        busy        <= 1'b1;
                        state_q     <= StSetup;
                    end
                end
                StSetup: begin
                    cnt_q <= '0;
                    if (len_q == '0) begin
                        state_q <= StSettle;
                    end else if (abort) begin
                        abort_hit_q <= 1'b1;
                        state_q     <= StSettle;
                    end else begin
                        sr_en   <= 1'b1;
                        sr_d    <= pick_bit('0, data_q, sr_dir, fill_q);
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    // The shift in flight completes on this edge regardless
                    cnt_q <= cnt_inc;
                    if (cnt_inc == len_q) begin
                        sr_en   <= 1'b0;
                        sr_d    <= 1'b0;
                        state_q <= StSettle;
                    end else if (abort) begin
                        sr_en       <= 1'b0;
                        sr_d        <= 1'b0;
                        abort_hit_q <= 1'b1;
                        state_q     <= StSettle;
                    end else begin
                        sr_d <= pick_bit(cnt_inc, data_q, sr_dir, fill_q);
                    end
                end
                StSettle: begin
                    result  <= sr_out;
                    state_q <= StDone;
                end
                StDone: begin
                    done      <= 1'b1;
                    aborted   <= abort_hit_q;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state_q   <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural shift-register model.
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_dir;
    logic [4:0] cmd_len;
    logic [3:0] cmd_data;
    logic       cmd_fill;
    logic       abort;
    logic       sr_d;
    logic       sr_en;
    logic       sr_dir;
    logic [3:0] sr_q;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [3:0] result;

    logic       preload;
    logic [3:0] preload_val;

    int n_tests = 0;
    int n_fail  = 0;
    int last_waits;

    shift_seq_ctrl #(.MSB(4), .CW(5)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .cmd_fill  (cmd_fill),
        .abort     (abort),
        .sr_d      (sr_d),
        .sr_en     (sr_en),
        .sr_dir    (sr_dir),
        .sr_out    (sr_q),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .result    (result)
    );

    always #5 clk = ~clk;

    // Behavioural bidirectional register, with a bench-side preload
    always @(posedge clk) begin
        if (preload) sr_q <= preload_val;
        else if (sr_en) sr_q <= sr_dir ? {sr_d, sr_q[3:1]} : {sr_q[2:0], sr_d};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command (cmd_valid left high) and follow it until done.
    task automatic run_cmd(input logic dir, input logic [4:0] len, input logic [3:0] data,
                           input logic fill, input int abort_at,
                           output logic [31:0] seq, output int n_en, output int done_e,
                           output logic dir_ok, output logic ready_ok);
        int e;
        seq = '0; n_en = 0; done_e = 999; dir_ok = 1'b1; ready_ok = 1'b1;
        cmd_dir = dir; cmd_len = len; cmd_data = data; cmd_fill = fill; cmd_valid = 1'b1;
        last_waits = 0;
        while (!cmd_ready && last_waits < 100) begin
            tick();
            last_waits++;
        end
        tick();
        e = 0;
        while (e < 100) begin
            if (sr_en) begin
                seq = {seq[30:0], sr_d};
                n_en++;
            end
            if (busy && sr_dir !== dir) dir_ok = 1'b0;
            if (busy && cmd_ready) ready_ok = 1'b0;
            if (done) begin
                if (!cmd_ready) ready_ok = 1'b0;
                done_e = e;
                break;
            end
            abort = (e == abort_at);
            tick();
            e++;
        end
        abort = 1'b0;
    endtask

    task automatic expect_cmd(input string tag, input logic dir, input logic [4:0] len,
                              input logic [3:0] data, input logic fill, input int abort_at,
                              input logic [31:0] exp_seq, input int exp_en, input int exp_done,
                              input logic [3:0] exp_res, input logic exp_ab);
        logic [31:0] seq;
        int          n_en;
        int          done_e;
        logic        dir_ok;
        logic        ready_ok;
        run_cmd(dir, len, data, fill, abort_at, seq, n_en, done_e, dir_ok, ready_ok);
        check({tag, "_seq"}, seq, exp_seq);
        check({tag, "_en_cycles"}, n_en, exp_en);
        check({tag, "_done_cycle"}, done_e, exp_done);
        check({tag, "_result"}, {28'd0, result}, {28'd0, exp_res});
        check({tag, "_aborted"}, {31'd0, aborted}, {31'd0, exp_ab});
        check({tag, "_dir_stable"}, {31'd0, dir_ok}, 32'd1);
        check({tag, "_ready"}, {31'd0, ready_ok}, 32'd1);
    endtask

    initial begin
        logic seen_done;
        rstn = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_len = '0; cmd_data = '0;
        cmd_fill = 1'b0; abort = 1'b0; preload = 1'b1; preload_val = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", {25'd0, cmd_ready, busy, done, aborted, sr_en, sr_d, sr_dir},
              {25'd0, 7'b1000000});
        check("reset_result", {28'd0, result}, 32'd0);
        preload = 1'b0;
        rstn = 1'b1;
        tick();

        // 1: dir=0, full word, register 0000 -> 1011
        expect_cmd("t1", 1'b0, 5'd4, 4'b1011, 1'b0, -1, 32'hB, 4, 7, 4'b1011, 1'b0);
        cmd_valid = 1'b0;
        tick();
        check("t1_done_pulse", {31'd0, done}, 32'd0);

        // 2: dir=1 with fill bits, register preloaded 0000 -> 1101
        preload = 1'b1; preload_val = 4'b0000;
        tick();
        preload = 1'b0;
        expect_cmd("t2", 1'b1, 5'd6, 4'b0110, 1'b1, -1, 32'h1B, 6, 9, 4'b1101, 1'b0);
        cmd_valid = 1'b0;
        tick();

        // 3: zero length, register untouched
        expect_cmd("t3", 1'b0, 5'd0, 4'b1111, 1'b1, -1, 32'h0, 0, 3, 4'b1101, 1'b0);
        cmd_valid = 1'b0;
        tick();

        // 4: abort on third shift cycle, 1101 -> 1011 -> 0110 -> 1100
        expect_cmd("t4", 1'b0, 5'd10, 4'b1001, 1'b0, 3, 32'h4, 3, 6, 4'b1100, 1'b1);

        // 5: back-to-back with cmd_valid held, alternating direction
        expect_cmd("t5a", 1'b0, 5'd4, 4'b0101, 1'b0, -1, 32'h5, 4, 7, 4'b0101, 1'b0);
        expect_cmd("t5b", 1'b1, 5'd3, 4'b0011, 1'b0, -1, 32'h6, 3, 6, 4'b0110, 1'b0);
        check("t5b_no_wait", last_waits, 32'd0);
        cmd_valid = 1'b0;
        tick();

        // Abort landing on the last shift edge: shift completes, not aborted
        expect_cmd("t7", 1'b0, 5'd2, 4'b1100, 1'b0, 2, 32'h3, 2, 5, 4'b1011, 1'b0);
        cmd_valid = 1'b0;
        tick();

        // Abort in SETUP: no shifts at all
        expect_cmd("t8", 1'b1, 5'd3, 4'b1111, 1'b0, 0, 32'h0, 0, 3, 4'b1011, 1'b1);
        cmd_valid = 1'b0;
        tick();

        // Maximum length must not wrap the counter
        expect_cmd("t9", 1'b0, 5'd31, 4'b1010, 1'b1, -1, 32'h57FF_FFFF, 31, 34, 4'b1111, 1'b0);
        cmd_valid = 1'b0;
        tick();

        // 6: reset mid-SHIFT after two shifts, 1111 -> 1110 -> 1101
        cmd_dir = 1'b0; cmd_len = 5'd8; cmd_data = 4'b0100; cmd_fill = 1'b0;
        check("t6_ready", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (3) tick();
        check("t6_en_before", {31'd0, sr_en}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("t6_async", {29'd0, sr_en, busy, cmd_ready}, 32'd1);
        seen_done = 1'b0;
        repeat (3) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        check("t6_no_done", {31'd0, seen_done}, 32'd0);
        check("t6_reg_hold", {28'd0, sr_q}, {28'd0, 4'b1101});
        rstn = 1'b1;
        tick();
        expect_cmd("t6b", 1'b1, 5'd2, 4'b0010, 1'b0, -1, 32'h1, 2, 5, 4'b1011, 1'b0);
        cmd_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
